mem_dump: RTL and testbench
===========================

MEM_DUMP -- requirements
Module: mem_dump

Interface
REQ-001 Parameter ADDR_W, default 15, memory word-address width.
REQ-002 Parameter DATA_W, default 16, memory word width; fixed at 16 for this revision.
REQ-003 clk  input  1  single system clock; all state changes on its rising edge.
REQ-004 reset  input  1  asynchronous, active-low reset; asserting it clears all state immediately, independent of clk.
REQ-005 start  input  1  one-cycle request to begin a dump; sampled only in IDLE.
REQ-006 start_addr  input  ADDR_W  first word address of the dump; sampled with start.
REQ-007 word_count  input  16  number of words to dump; sampled with start.
REQ-008 mem_address  output  ADDR_W  read address to the synchronous-read memory.
REQ-009 mem_q  input  16  read data, valid one clk after mem_address is presented.
REQ-010 tx_data  output  8  byte to the byte sink (UART TX).
REQ-011 tx_valid  output  1  tx_data holds a byte to transfer.
REQ-012 tx_ready  input  1  sink accepts; a transfer occurs on a clk edge with tx_valid and tx_ready both high.
REQ-013 busy  output  1  high in every state except IDLE.
REQ-014 done  output  1  one-cycle pulse after the checksum byte transfers.

Function
REQ-015 The FSM SHALL use the states IDLE, READ, WAIT, SEND_HI, SEND_LO, SEND_SUM and DONE.
REQ-016 IDLE + start: latch start_addr into the address counter and word_count into the remaining counter, clear the checksum, and go to READ; if word_count==0, go to SEND_SUM instead.
REQ-017 READ: drive mem_address = address counter for one cycle, then go to WAIT.
REQ-018 WAIT: capture mem_q into a 16-bit word register, then go to SEND_HI; read latency is fixed at 1 cycle.
REQ-019 SEND_HI: tx_valid=1 and tx_data=word[15:8]; on transfer, XOR the byte into the checksum and go to SEND_LO.
REQ-020 SEND_LO: tx_valid=1 and tx_data=word[7:0]; on transfer, XOR the byte into the checksum and decrement remaining; if remaining was 1, go to SEND_SUM, else increment the address and go to READ.
REQ-021 SEND_SUM: tx_valid=1 and tx_data=checksum; on transfer, go to DONE.
REQ-022 DONE: done=1 for exactly one cycle, then go to IDLE.
REQ-023 tx_data SHALL stay stable while tx_valid=1 and tx_ready=0; tx_valid SHALL not drop before the transfer completes.
REQ-024 tx_valid SHALL be 0 in IDLE, READ, WAIT and DONE.
REQ-025 start SHALL be ignored while busy=1.
REQ-026 The address counter SHALL wrap from 2^ADDR_W-1 to 0, modulo ADDR_W bits.
REQ-027 word_count=0xFFFF SHALL dump 65535 words, including address wrap; there is no special case.
REQ-028 The checksum SHALL be the 8-bit XOR of all data bytes sent in the current dump.
REQ-029 The minimum per-word cost SHALL be 4 cycles (READ, WAIT, SEND_HI, SEND_LO) when tx_ready is held high.

Reset
REQ-030 While reset=0: state=IDLE; tx_valid=0, busy=0, done=0; tx_data=0, mem_address=0; all counters, the word register and the checksum =0.
REQ-031 Reset asserted mid-dump SHALL abort at once with no further bytes; after release, the block SHALL wait in IDLE for a new start.

Structure
REQ-032 A shared package hack_pkg SHALL hold the state enumeration constants and the ADDR_W/DATA_W defaults.
REQ-033 A single sub-module byte_tx_reg (valid/data holding register with transfer detect) SHALL be used for the tx side; everything else stays flat.

Verification
REQ-034 Memory[0]=0x1234, start_addr=0, word_count=1, tx_ready=1 -> bytes 0x12, 0x34, 0x26; done pulses once; busy returns low.
REQ-035 word_count=0, start_addr=5 -> single byte 0x00, done pulse, and mem_address never leaves reset value 0 during the dump.
REQ-036 Memory[32767]=0xABCD and Memory[0]=0x0102, start_addr=32767, word_count=2 -> mem_address sequence 32767 then 0; bytes AB CD 01 02 then checksum 0x65.
REQ-037 tx_ready held low 5 cycles during SEND_HI -> tx_valid stays 1 and tx_data stays equal to the high byte; transfer occurs on the first cycle with ready high.
REQ-038 start pulsed again mid-dump -> ignored; the byte stream is identical to the undisturbed run.
REQ-039 reset asserted during SEND_LO -> tx_valid, busy and done are 0 immediately (asynchronous); a new start then completes a correct dump.

Source files
------------

// File: rtl/hack_pkg.sv
// Shared definitions for the memory dump block: default widths, FSM state
// encoding and the checksum helper.
package hack_pkg;

    localparam int ADDR_W_DEF = 15;
    localparam int DATA_W_DEF = 16;

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        READ     = 3'd1,
        WAIT     = 3'd2,
        SEND_HI  = 3'd3,
        SEND_LO  = 3'd4,
        SEND_SUM = 3'd5,
        DONE     = 3'd6
    } state_e;

    function automatic logic [7:0] xor_byte(input logic [7:0] sum, input logic [7:0] b);
        return sum ^ b;
    endfunction

endpackage

// File: rtl/byte_tx_reg.sv
// Valid/data holding register for the byte sink; a byte stays put until the
// sink takes it, and xfer_o flags the accepting cycle.
module byte_tx_reg (
    input  logic       clk,
    input  logic       reset,
    input  logic       load_i,
    input  logic [7:0] data_i,
    input  logic       ready_i,
    output logic       valid_o,
    output logic [7:0] data_o,
    output logic       xfer_o
);

    logic       valid_q;
    logic [7:0] data_q;

    assign valid_o = valid_q;
    assign data_o  = data_q;
    assign xfer_o  = valid_q & ready_i;

    // Load has priority so back-to-back bytes keep valid high across the handoff.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            valid_q <= 1'b0;
            data_q  <= 8'h00;
        end else if (load_i) begin
            valid_q <= 1'b1;
            data_q  <= data_i;
        end else if (xfer_o) begin
            valid_q <= 1'b0;
        end
    end

endmodule

// File: rtl/mem_dump.sv
// Streams a block of 16-bit memory words to a byte sink, high byte first,
// followed by an XOR checksum byte.
module mem_dump
    import hack_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int DATA_W = DATA_W_DEF
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [ADDR_W-1:0] start_addr,
    input  logic [15:0]       word_count,
    output logic [ADDR_W-1:0] mem_address,
    input  logic [DATA_W-1:0] mem_q,
    output logic [7:0]        tx_data,
    output logic              tx_valid,
    input  logic              tx_ready,
    output logic              busy,
    output logic              done
);

    state_e            state_q;
    logic [ADDR_W-1:0] addr_q;
    logic [ADDR_W-1:0] mem_addr_q;
    logic [15:0]       remaining_q;
    logic [DATA_W-1:0] word_q;
    logic [7:0]        sum_q;
    logic              busy_q;
    logic              done_q;

    logic              tx_load_s;
    logic [7:0]        tx_byte_s;
    logic              tx_xfer_s;
    logic [ADDR_W-1:0] addr_inc_s;

    assign mem_address = mem_addr_q;
    assign busy        = busy_q;
    assign done        = done_q;
    assign addr_inc_s  = addr_q + ADDR_W'(1'b1);

    byte_tx_reg u_tx (
        .clk     (clk),
        .reset   (reset),
        .load_i  (tx_load_s),
        .data_i  (tx_byte_s),
        .ready_i (tx_ready),
        .valid_o (tx_valid),
        .data_o  (tx_data),
        .xfer_o  (tx_xfer_s)
    );

    // Queue the next byte in the cycle before its send state begins.
    always_comb begin
        tx_load_s = 1'b0;
        tx_byte_s = 8'h00;
        case (state_q)
            IDLE: begin
                if (start && (word_count == 16'd0)) begin
                    tx_load_s = 1'b1;
                    tx_byte_s = 8'h00;
                end else begin
                    tx_load_s = 1'b0;
                end
            end
            WAIT: begin
                tx_load_s = 1'b1;
                tx_byte_s = mem_q[DATA_W-1 -: 8];
            end
            SEND_HI: begin
                if (tx_xfer_s) begin
                    tx_load_s = 1'b1;
                    tx_byte_s = word_q[7:0];
                end else begin
                    tx_load_s = 1'b0;
                end
            end
            SEND_LO: begin
                if (tx_xfer_s && (remaining_q == 16'd1)) begin
                    tx_load_s = 1'b1;
                    tx_byte_s = xor_byte(sum_q, word_q[7:0]);
                end else begin
                    tx_load_s = 1'b0;
                end
            end
            default: begin
                tx_load_s = 1'b0;
            end
        endcase
    end

    // Main dump sequencer with registered busy/done/address outputs.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= IDLE;
            addr_q      <= '0;
            mem_addr_q  <= '0;
            remaining_q <= 16'd0;
            word_q      <= '0;
            sum_q       <= 8'h00;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (start) begin
                        addr_q      <= start_addr;
                        remaining_q <= word_count;
                        sum_q       <= 8'h00;
                        busy_q      <= 1'b1;
                        if (word_count == 16'd0) begin
                            state_q <= SEND_SUM;
                        end else begin
                            mem_addr_q <= start_addr;
                            state_q    <= READ;
                        end
                    end
                end
                READ: begin
                    state_q <= WAIT;
                end
                WAIT: begin
                    word_q  <= mem_q;
                    state_q <= SEND_HI;
                end
                SEND_HI: begin
                    if (tx_xfer_s) begin
                        sum_q   <= xor_byte(sum_q, word_q[DATA_W-1 -: 8]);
                        state_q <= SEND_LO;
                    end
                end
                SEND_LO: begin
                    if (tx_xfer_s) begin
                        sum_q       <= xor_byte(sum_q, word_q[7:0]);
                        remaining_q <= remaining_q - 16'd1;
                        if (remaining_q == 16'd1) begin
                            state_q <= SEND_SUM;
                        end else begin
                            addr_q     <= addr_inc_s;
                            mem_addr_q <= addr_inc_s;
                            state_q    <= READ;
                        end
                    end
                end
                SEND_SUM: begin
                    if (tx_xfer_s) begin
                        done_q  <= 1'b1;
                        state_q <= DONE;
                    end
                end
                DONE: begin
                    busy_q  <= 1'b0;
                    state_q <= IDLE;
                end
                default: begin
                    busy_q  <= 1'b0;
                    state_q <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_dump.sv
// Directed bench for mem_dump: table-driven dumps plus stall, restart and
// mid-dump reset sequences against a synchronous-read memory model.
module tb_mem_dump;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        start = 1'b0;
    logic [14:0] start_addr = 15'd0;
    logic [15:0] word_count = 16'd0;
    logic [14:0] mem_address;
    logic [15:0] mem_q = 16'h0000;
    logic [7:0]  tx_data;
    logic        tx_valid;
    logic        tx_ready = 1'b1;
    logic        busy;
    logic        done;

    logic [15:0] mem [0:32767];
    logic [7:0]  bytes_q [$];
    logic [14:0] addr_log [$];
    logic [14:0] addr_prev;
    int          done_cnt = 0;
    int          total = 0;
    int          bad = 0;

    typedef struct {
        logic [14:0] sa;
        logic [15:0] wc;
        int          npre;
        logic [44:0] pa;
        logic [47:0] pd;
        int          nb;
        logic [55:0] eb;
        int          lat;
        int          na;
        logic [44:0] ea;
    } vec_t;

    vec_t v [4];

    mem_dump dut (
        .clk         (clk),
        .reset       (reset),
        .start       (start),
        .start_addr  (start_addr),
        .word_count  (word_count),
        .mem_address (mem_address),
        .mem_q       (mem_q),
        .tx_data     (tx_data),
        .tx_valid    (tx_valid),
        .tx_ready    (tx_ready),
        .busy        (busy),
        .done        (done)
    );

    always #5 clk = ~clk;

    always @(posedge clk) mem_q <= mem[mem_address];

    always @(posedge clk) begin
        if (tx_valid && tx_ready) bytes_q.push_back(tx_data);
        if (done) done_cnt++;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic log_addr();
        if (mem_address !== addr_prev) begin
            addr_log.push_back(mem_address);
            addr_prev = mem_address;
        end
    endtask

    task automatic start_dump(input logic [14:0] sa, input logic [15:0] wc);
        addr_prev = mem_address;
        addr_log.delete();
        bytes_q.delete();
        done_cnt = 0;
        @(negedge clk);
        start = 1'b1;
        start_addr = sa;
        word_count = wc;
        @(posedge clk);
        #1;
        start = 1'b0;
        log_addr();
    endtask

    task automatic wait_done(input int glitch, output int cycles);
        cycles = 0;
        while (done !== 1'b1 && cycles < 300) begin
            if (cycles == glitch) begin
                start = 1'b1;
                start_addr = 15'd0;
                word_count = 16'd5;
            end
            @(posedge clk);
            #1;
            start = 1'b0;
            cycles++;
            log_addr();
        end
        if (done !== 1'b1) chk("done_timeout", 32'(cycles), 32'd0);
    endtask

    task automatic finish_dump(input string tag);
        @(posedge clk);
        #1;
        chk({tag, "_done_cnt"}, 32'(done_cnt), 32'd1);
        chk({tag, "_done_low"}, {31'd0, done}, 32'd0);
        chk({tag, "_busy_low"}, {31'd0, busy}, 32'd0);
    endtask

    task automatic run_vec(input int idx, input int glitch);
        int cyc;
        string tag;
        tag = $sformatf("vec%0d", idx);
        for (int i = 0; i < v[idx].npre; i++)
            mem[v[idx].pa[44-15*i -: 15]] = v[idx].pd[47-16*i -: 16];
        start_dump(v[idx].sa, v[idx].wc);
        wait_done(glitch, cyc);
        chk({tag, "_latency"}, 32'(cyc), 32'(v[idx].lat));
        chk({tag, "_nbytes"}, 32'(bytes_q.size()), 32'(v[idx].nb));
        for (int i = 0; i < v[idx].nb && i < bytes_q.size(); i++)
            chk($sformatf("%s_byte%0d", tag, i), {24'd0, bytes_q[i]}, {24'd0, v[idx].eb[55-8*i -: 8]});
        chk({tag, "_naddr"}, 32'(addr_log.size()), 32'(v[idx].na));
        for (int i = 0; i < v[idx].na && i < addr_log.size(); i++)
            chk($sformatf("%s_addr%0d", tag, i), {17'd0, addr_log[i]}, {17'd0, v[idx].ea[44-15*i -: 15]});
        finish_dump(tag);
    endtask

    initial begin
        int n;
        logic [7:0] stall_exp [3];

        for (int i = 0; i < 32768; i++) mem[i] = 16'h0000;

        v[0] = '{sa: 15'd5, wc: 16'd0, npre: 0, pa: 45'd0, pd: 48'd0,
                 nb: 1, eb: 56'h00_000000000000, lat: 1, na: 0, ea: 45'd0};
        v[1] = '{sa: 15'd0, wc: 16'd1, npre: 1, pa: {15'd0, 30'd0}, pd: {16'h1234, 32'd0},
                 nb: 3, eb: {24'h123426, 32'd0}, lat: 5, na: 0, ea: 45'd0};
        v[2] = '{sa: 15'd32767, wc: 16'd2, npre: 2, pa: {15'd32767, 15'd0, 15'd0},
                 pd: {16'hABCD, 16'h0102, 16'h0000},
                 nb: 5, eb: {40'hABCD010265, 16'd0}, lat: 9, na: 2, ea: {15'd32767, 15'd0, 15'd0}};
        v[3] = '{sa: 15'd10, wc: 16'd3, npre: 3, pa: {15'd10, 15'd11, 15'd12},
                 pd: {16'hFF00, 16'h00FF, 16'h8001},
                 nb: 7, eb: 56'hFF0000FF800181, lat: 13, na: 3, ea: {15'd10, 15'd11, 15'd12}};

        // Reset state
        #3;
        chk("rst_tx_valid", {31'd0, tx_valid}, 32'd0);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_done", {31'd0, done}, 32'd0);
        chk("rst_tx_data", {24'd0, tx_data}, 32'd0);
        chk("rst_mem_address", {17'd0, mem_address}, 32'd0);
        @(negedge clk);
        @(negedge clk);
        reset = 1'b1;
        repeat (2) @(posedge clk);
        #1;

        for (int k = 0; k < 4; k++) run_vec(k, -1);

        // Sink stalls for five cycles on the high byte
        mem[0] = 16'h1234;
        tx_ready = 1'b0;
        start_dump(15'd0, 16'd1);
        n = 0;
        while (tx_valid !== 1'b1 && n < 20) begin
            @(posedge clk);
            #1;
            n++;
        end
        chk("stall_valid_seen", {31'd0, tx_valid}, 32'd1);
        for (int i = 0; i < 5; i++) begin
            @(posedge clk);
            #1;
            chk($sformatf("stall_valid%0d", i), {31'd0, tx_valid}, 32'd1);
            chk($sformatf("stall_data%0d", i), {24'd0, tx_data}, 32'h12);
        end
        chk("stall_no_xfer", 32'(bytes_q.size()), 32'd0);
        tx_ready = 1'b1;
        @(posedge clk);
        #1;
        chk("stall_first_xfer", 32'(bytes_q.size()), 32'd1);
        chk("stall_lo_data", {24'd0, tx_data}, 32'h34);
        wait_done(-1, n);
        stall_exp = '{8'h12, 8'h34, 8'h26};
        chk("stall_nbytes", 32'(bytes_q.size()), 32'd3);
        for (int i = 0; i < 3 && i < bytes_q.size(); i++)
            chk($sformatf("stall_byte%0d", i), {24'd0, bytes_q[i]}, {24'd0, stall_exp[i]});
        finish_dump("stall");

        // Second start while busy must not disturb the stream
        run_vec(3, 3);

        // Asynchronous reset while the low byte is on offer
        mem[0] = 16'h1234;
        start_dump(15'd0, 16'd1);
        n = 0;
        while (!(tx_valid === 1'b1 && tx_data === 8'h34) && n < 20) begin
            @(posedge clk);
            #1;
            n++;
        end
        chk("rst_mid_in_lo", {24'd0, tx_data}, 32'h34);
        #2;
        reset = 1'b0;
        #1;
        chk("rst_mid_tx_valid", {31'd0, tx_valid}, 32'd0);
        chk("rst_mid_busy", {31'd0, busy}, 32'd0);
        chk("rst_mid_done", {31'd0, done}, 32'd0);
        repeat (2) @(negedge clk);
        reset = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_after_busy", {31'd0, busy}, 32'd0);
        chk("rst_after_nbytes", 32'(bytes_q.size()), 32'd1);
        run_vec(3, -1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
